writeback_unit: RTL

Multi-cycle CPU writeback stage that drives the register file write port. It accepts a writeback request from decode/execute and, for loads, waits for data memory. It applies load sign/zero extension, selects among the ALU result, memory data and PC+4, and presents one write to the register file during the writeback state (`i_state == 10`). It is the producer side of the register file's `RegWrite` / `write_register` / `write_data` interface.

---
 rtl/writeback_unit_if.sv | 42 ++++
 rtl/writeback_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// Writeback bundle: request from decode/execute, load data return, and the
// register-file write port (RegWrite / write_register / write_data) plus status.
// Latency and backpressure are set by writeback_unit; this file only groups the wires.
//
// Ports (as seen by the unit, modport slave):
//   in : i_state, i_start, i_rd, i_wb_sel, i_funct3, i_alu_result, i_pc,
//        i_mem_valid, i_mem_rdata
//   out: o_RegWrite, o_write_register, o_write_data, o_busy, o_done, o_wb_miss
interface writeback_unit_if #(
  parameter int DATA_W = 64
);
  logic [4:0]        i_state;
  logic              i_start;
  logic [4:0]        i_rd;
  logic [1:0]        i_wb_sel;
  logic [2:0]        i_funct3;
  logic [DATA_W-1:0] i_alu_result;
  logic [DATA_W-1:0] i_pc;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_RegWrite;
  logic [4:0]        o_write_register;
  logic [DATA_W-1:0] o_write_data;
  logic              o_busy;
  logic              o_done;
  logic              o_wb_miss;

  // The writeback unit consumes requests and produces the register-file write.
  modport slave (
    input  i_state, i_start, i_rd, i_wb_sel, i_funct3, i_alu_result, i_pc,
           i_mem_valid, i_mem_rdata,
    output o_RegWrite, o_write_register, o_write_data, o_busy, o_done, o_wb_miss
  );

  // The surrounding CPU drives requests and observes the write port.
  modport master (
    output i_state, i_start, i_rd, i_wb_sel, i_funct3, i_alu_result, i_pc,
           i_mem_valid, i_mem_rdata,
    input  o_RegWrite, o_write_register, o_write_data, o_busy, o_done, o_wb_miss
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / extended load data / PC+4 and drives one register-file write.
// Latency: READY one edge after i_start (ALU, PC+4, none) or after i_mem_valid (loads).
// Backpressure: i_start is ignored while busy (not queued); write held until global state 10.
//
// Ports: i_clk, i_rst_n (async active-low), wb (writeback_unit_if.slave, see interface file).
// All outputs are registered.
module writeback_unit #(
  parameter int DATA_W = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  writeback_unit_if.slave wb
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_READY    = 2'd2
  } state_t;

  localparam logic [4:0] WB_CYCLE = 5'd10;
  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_rd, w_rd_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic              r_suppress, w_suppress_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_regwrite, w_regwrite_nxt;
  logic              r_done, w_done_nxt;
  logic              r_miss, w_miss_nxt;
  logic              r_busy;

  logic              w_wb_cycle;
  logic              w_start_suppress;
  logic [DATA_W-1:0] w_direct_data;
  logic [DATA_W-1:0] w_ext_data;

  assign w_wb_cycle       = (wb.i_state == WB_CYCLE);
  assign w_start_suppress = (wb.i_wb_sel == SEL_NONE) || (wb.i_rd == 5'd0);

  // Non-load sources, captured in the same edge that accepts the request.
  always_comb begin
    w_direct_data = '0;
    case (wb.i_wb_sel)
      SEL_ALU: w_direct_data = wb.i_alu_result;
      SEL_PC4: w_direct_data = wb.i_pc + DATA_W'(4);  // wraps at 2^DATA_W
      default: w_direct_data = '0;
    endcase
  end

  // Load extension uses the funct3 latched at request time, not the live input.
  always_comb begin
    w_ext_data = wb.i_mem_rdata;
    case (r_funct3)
      3'b000: w_ext_data = {{(DATA_W-8){wb.i_mem_rdata[7]}},   wb.i_mem_rdata[7:0]};
      3'b001: w_ext_data = {{(DATA_W-16){wb.i_mem_rdata[15]}}, wb.i_mem_rdata[15:0]};
      3'b010: w_ext_data = {{(DATA_W-32){wb.i_mem_rdata[31]}}, wb.i_mem_rdata[31:0]};
      3'b100: w_ext_data = {{(DATA_W-8){1'b0}},  wb.i_mem_rdata[7:0]};
      3'b101: w_ext_data = {{(DATA_W-16){1'b0}}, wb.i_mem_rdata[15:0]};
      3'b110: w_ext_data = {{(DATA_W-32){1'b0}}, wb.i_mem_rdata[31:0]};
      default: w_ext_data = wb.i_mem_rdata;         // 011 ld, 111 treated as ld
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_nxt       = r_rd;
    w_funct3_nxt   = r_funct3;
    w_suppress_nxt = r_suppress;
    w_data_nxt     = r_data;
    w_regwrite_nxt = r_regwrite;
    w_done_nxt     = 1'b0;
    w_miss_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_regwrite_nxt = 1'b0;
        // A coincident state 10 is not a write opportunity: the request only
        // becomes READY after this edge.
        if (wb.i_start) begin
          w_rd_nxt       = wb.i_rd;
          w_funct3_nxt   = wb.i_funct3;
          w_suppress_nxt = w_start_suppress;
          if (wb.i_wb_sel == SEL_MEM) begin
            w_state_nxt = S_WAIT_MEM;
          end else begin
            w_data_nxt     = w_direct_data;
            w_regwrite_nxt = !w_start_suppress;
            w_state_nxt    = S_READY;
          end
        end
      end

      S_WAIT_MEM: begin
        // Data arriving in the writeback cycle wins; the write then waits
        // for the next state 10.
        if (wb.i_mem_valid) begin
          w_data_nxt     = w_ext_data;
          w_regwrite_nxt = !r_suppress;
          w_state_nxt    = S_READY;
        end else if (w_wb_cycle) begin
          w_miss_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_READY: begin
        // The register file writes on this same edge, so leaving here gives
        // exactly one write per request.
        if (w_wb_cycle) begin
          w_regwrite_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end

      default: begin
        w_regwrite_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd       <= '0;
      r_funct3   <= '0;
      r_suppress <= 1'b0;
      r_data     <= '0;
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_miss     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rd       <= w_rd_nxt;
      r_funct3   <= w_funct3_nxt;
      r_suppress <= w_suppress_nxt;
      r_data     <= w_data_nxt;
      r_regwrite <= w_regwrite_nxt;
      r_done     <= w_done_nxt;
      r_miss     <= w_miss_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign wb.o_RegWrite       = r_regwrite;
  assign wb.o_write_register = r_rd;
  assign wb.o_write_data     = r_data;
  assign wb.o_busy           = r_busy;
  assign wb.o_done           = r_done;
  assign wb.o_wb_miss        = r_miss;

endmodule
